// File: rtl/dbus_pkg.sv
// ============================================================================
// Module  : dbus_pkg
// Brief   : Shared types and constants for the dbus_resp data-bus responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_DATA
`define W_DATA 32
`endif

package dbus_pkg;
   localparam int LATENCY_MAX = 7;
   localparam int LANE_W      = 8;
   localparam int N_LANES     = `W_DATA / LANE_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dbus_state_t;
endpackage

`default_nettype wire

// File: rtl/dbus_ram.sv
// ============================================================================
// Module  : dbus_ram
// Brief   : Synchronous single-port RAM, 2^DEPTH_LOG2 words, byte-lane writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_ram import dbus_pkg::*; #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [N_LANES-1:0]    we,
   input  logic [`W_DATA-1:0]    wdata,
   output logic [`W_DATA-1:0]    rdata
);

   logic [`W_DATA-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_LANES; i++) begin
         if (we[i]) r_mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
      rdata <= r_mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/dbus_resp.sv
// ============================================================================
// Module  : dbus_resp
// Brief   : Fixed-latency data-bus responder in front of a byte-enable RAM.
//           DBUS_RESP_WBUF_EN adds a one-entry posted write buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_resp import dbus_pkg::*; #(
   parameter int                 DEPTH_LOG2 = 10,
   parameter int                 LATENCY    = 2,
   parameter logic [`W_ADDR-1:0] BASE       = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dbus_en,
   input  logic [N_LANES-1:0]   dbus_we,
   input  logic [`W_ADDR-1:0]   dbus_addr,
   input  logic [`W_DATA-1:0]   dbus_data,
   output logic [`W_DATA-1:0]   dbus_rdata,
   output logic                 dbus_stall,
   output logic                 dbus_err
);

   localparam logic [2:0] C_LAT_M1 = 3'(LATENCY - 1);

   dbus_state_t             r_state, w_next;
   logic [2:0]              r_cnt;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic [N_LANES-1:0]      r_we;
   logic [`W_DATA-1:0]      r_wdata;
   logic                    r_in_ap;

   logic                    w_in_ap, w_accept, w_block, w_post, w_wb_err;
   logic [DEPTH_LOG2-1:0]   w_idx, w_ram_idx;
   logic [N_LANES-1:0]      w_ram_we;
   logic [`W_DATA-1:0]      w_ram_wdata, w_ram_q;
   logic [1:0]              w_unused_addr;

   assign w_idx         = dbus_addr[DEPTH_LOG2+1:2];
   assign w_in_ap       = dbus_addr[`W_ADDR-1:DEPTH_LOG2+2] == BASE[`W_ADDR-1:DEPTH_LOG2+2];
   assign w_unused_addr = dbus_addr[1:0];

`ifdef DBUS_RESP_WBUF_EN
   logic                  r_wb_valid, r_wb_err, r_blocked, w_drain;
   logic [2:0]            r_wb_cnt;
   logic [DEPTH_LOG2-1:0] r_wb_idx;
   logic [N_LANES-1:0]    r_wb_we;
   logic [`W_DATA-1:0]    r_wb_data;

   // A request that had to wait for a drain is then served as a normal access.
   assign w_block  = r_wb_valid;
   assign w_post   = (dbus_we != '0) && !r_wb_valid && !r_blocked;
   assign w_drain  = r_wb_valid && (r_wb_cnt == 3'd0);
   assign w_wb_err = r_wb_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_err   <= 1'b0;
         r_blocked  <= 1'b0;
         r_wb_cnt   <= 3'd0;
         r_wb_idx   <= '0;
         r_wb_we    <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_err <= 1'b0;
         if (r_state == ST_IDLE && dbus_en && w_post) begin
            r_wb_valid <= w_in_ap;
            r_wb_err   <= !w_in_ap;
            r_wb_cnt   <= C_LAT_M1;
            r_wb_idx   <= w_idx;
            r_wb_we    <= dbus_we;
            r_wb_data  <= dbus_data;
         end else if (w_drain) begin
            r_wb_valid <= 1'b0;
         end else if (r_wb_valid) begin
            r_wb_cnt <= r_wb_cnt - 3'd1;
         end
         if (w_accept)
            r_blocked <= 1'b0;
         else if (r_state == ST_IDLE && dbus_en && r_wb_valid)
            r_blocked <= 1'b1;
      end
   end
`else
   assign w_block  = 1'b0;
   assign w_post   = 1'b0;
   assign w_wb_err = 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      dbus_stall = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dbus_en) begin
               if (w_block) begin
                  dbus_stall = 1'b1;
               end else if (!w_post) begin
                  w_accept   = 1'b1;
                  dbus_stall = 1'b1;
                  w_next     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            dbus_stall = 1'b1;
            if (r_cnt <= 3'd1) w_next = ST_RESP;
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      // stall is combinational on dbus_en, so reset must mask it directly
      if (rst) dbus_stall = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_idx   <= '0;
         r_we    <= '0;
         r_wdata <= '0;
         r_in_ap <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt   <= C_LAT_M1;
            r_idx   <= w_idx;
            r_we    <= dbus_we;
            r_wdata <= dbus_data;
            r_in_ap <= w_in_ap;
         end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end
      end
   end

   // The RAM read is launched one cycle ahead of RESP: from the live bus in
   // the accept cycle, from the latched index while waiting.
   always_comb begin
      w_ram_idx   = (r_state == ST_IDLE) ? w_idx : r_idx;
      w_ram_we    = '0;
      w_ram_wdata = r_wdata;
      if (r_state == ST_RESP && r_in_ap) w_ram_we = r_we;
`ifdef DBUS_RESP_WBUF_EN
      if (w_drain) begin
         w_ram_idx   = r_wb_idx;
         w_ram_we    = r_wb_we;
         w_ram_wdata = r_wb_data;
      end
`endif
   end

   dbus_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .addr  (w_ram_idx),
      .we    (w_ram_we),
      .wdata (w_ram_wdata),
      .rdata (w_ram_q)
   );

   assign dbus_rdata = (r_state == ST_RESP && r_in_ap && r_we == '0) ? w_ram_q : '0;
   assign dbus_err   = (r_state == ST_RESP && !r_in_ap) || w_wb_err;

endmodule

`default_nettype wire

// File: tb/tb_dbus_resp.sv
// ============================================================================
// Module  : tb_dbus_resp
// Brief   : Scoreboard bench for dbus_resp (LATENCY=2 main instance plus a
//           LATENCY=1 instance); honours DBUS_RESP_WBUF_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_resp;

   localparam int LAT = 2;
`ifdef DBUS_RESP_WBUF_EN
   localparam int C_WST   = 0;
   localparam int C_RAW_ST = 2 * LAT;
`else
   localparam int C_WST   = LAT;
   localparam int C_RAW_ST = LAT;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stalls;
      bit          is_read;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dbus_en = 1'b0;
   logic [3:0]  dbus_we = '0;
   logic [31:0] dbus_addr = '0;
   logic [31:0] dbus_data = '0;
   logic [31:0] dbus_rdata;
   logic        dbus_stall, dbus_err;

   logic        en1 = 1'b0;
   logic [3:0]  we1 = '0;
   logic [31:0] addr1 = '0;
   logic [31:0] data1 = '0;
   logic [31:0] rdata1;
   logic        stall1, err1;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic        pend_err = 1'b0;
   exp_t        sb[$];
   logic [31:0] model [int];

   always #5 clk = ~clk;

   dbus_resp #(.DEPTH_LOG2(10), .LATENCY(LAT), .BASE(32'h0)) dut (
      .clk(clk), .rst(rst), .dbus_en(dbus_en), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_data(dbus_data), .dbus_rdata(dbus_rdata),
      .dbus_stall(dbus_stall), .dbus_err(dbus_err));

   dbus_resp #(.DEPTH_LOG2(10), .LATENCY(1), .BASE(32'h0)) dut1 (
      .clk(clk), .rst(rst), .dbus_en(en1), .dbus_we(we1),
      .dbus_addr(addr1), .dbus_data(data1), .dbus_rdata(rdata1),
      .dbus_stall(stall1), .dbus_err(err1));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One access: expectation pushed at drive time, popped at the first non-stall cycle.
   task automatic access(input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] data, input int exp_stalls);
      exp_t        e;
      int          n;
      int          widx;
      logic [31:0] cur;
      logic        inap;
      @(negedge clk);
      dbus_en = 1'b1; dbus_we = we; dbus_addr = addr; dbus_data = data;
      widx = int'(addr[11:2]);
      inap = (addr[31:12] == 20'h0);
      cur  = model.exists(widx) ? model[widx] : 32'hx;
      e.err = !inap; e.stalls = exp_stalls; e.is_read = (we == 4'h0);
      e.rdata = (we == 4'h0 && inap) ? cur : 32'h0;
      if (we != 4'h0 && inap) begin
         for (int i = 0; i < 4; i++)
            if (we[i]) cur[i*8 +: 8] = data[i*8 +: 8];
         model[widx] = cur;
      end
      sb.push_back(e);
      #1;
      check_val("err_before_resp", {31'h0, dbus_err}, {31'h0, pend_err});
      pend_err = 1'b0;
      n = 0;
      while (dbus_stall && n < 40) begin
         n++;
         @(negedge clk); #1;
      end
      e = sb.pop_front();
      check_val("stall_cycles", n, e.stalls);
      if (n == 0) begin
         pend_err = e.err;
      end else begin
         check_val("resp_err", {31'h0, dbus_err}, {31'h0, e.err});
         if (e.is_read) check_val("resp_rdata", dbus_rdata, e.rdata);
      end
   endtask

   // Idle cycles with write enables asserted but dbus_en low: must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dbus_en = 1'b0; dbus_we = 4'hF; dbus_data = 32'hFFFF_FFFF;
         #1;
         check_val("idle_stall", {31'h0, dbus_stall}, 32'h0);
         check_val("idle_rdata", dbus_rdata, 32'h0);
         check_val("idle_err", {31'h0, dbus_err}, {31'h0, (i == 0) ? pend_err : 1'b0});
      end
      pend_err = 1'b0;
   endtask

   initial begin
      // reset state, including a request held during reset
      repeat (2) @(negedge clk);
      dbus_en = 1'b1; dbus_addr = 32'h10;
      #1;
      check_val("rst_stall", {31'h0, dbus_stall}, 32'h0);
      check_val("rst_rdata", dbus_rdata, 32'h0);
      check_val("rst_err", {31'h0, dbus_err}, 32'h0);
      @(negedge clk);
      dbus_en = 1'b0; rst = 1'b0;

      access(4'hF, 32'h10, 32'hDEAD_BEEF, C_WST);  idle(LAT + 1);
      access(4'h0, 32'h10, 32'h0, LAT);
      access(4'hF, 32'h14, 32'h1122_3344, C_WST);  idle(LAT + 1);
      access(4'b0001, 32'h14, 32'h0000_00AA, C_WST); idle(LAT + 1);
      access(4'h0, 32'h14, 32'h0, LAT);
      access(4'hF, 32'h18, 32'hA5A5_A5A5, C_WST);  idle(LAT + 1);
      access(4'b1100, 32'h1A, 32'h1234_0000, C_WST); idle(LAT + 1);
      access(4'h0, 32'h18, 32'h0, LAT);
      access(4'hF, 32'hFFC, 32'h0F0F_0F0F, C_WST); idle(LAT + 1);
      access(4'h0, 32'hFFC, 32'h0, LAT);

      // outside the aperture: read and aliasing write
      access(4'h0, 32'h1000, 32'h0, LAT);
      access(4'hF, 32'h1010, 32'h0BAD_0BAD, C_WST); idle(LAT + 1);
      access(4'h0, 32'h10, 32'h0, LAT);

      // back-to-back reads
      access(4'h0, 32'h10, 32'h0, LAT);
      access(4'h0, 32'h14, 32'h0, LAT);
      idle(1);

      // reset in the middle of a write
      access(4'hF, 32'h20, 32'hCAFE_F00D, C_WST); idle(LAT + 1);
      @(negedge clk);
      dbus_en = 1'b1; dbus_we = 4'hF; dbus_addr = 32'h20; dbus_data = 32'h55;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("midrst_stall", {31'h0, dbus_stall}, 32'h0);
      check_val("midrst_rdata", dbus_rdata, 32'h0);
      check_val("midrst_err", {31'h0, dbus_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0; dbus_en = 1'b0;
      idle(LAT + 2);
      access(4'h0, 32'h20, 32'h0, LAT);

      // write immediately followed by a read of the same word
      idle(1);
      access(4'hF, 32'h30, 32'h7766_5544, C_WST);
      access(4'h0, 32'h30, 32'h0, C_RAW_ST);
      idle(1);

      // LATENCY=1 instance, continuous reads: stall alternates every cycle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en1 = 1'b1; we1 = 4'h0; addr1 = (i < 2) ? 32'h40 : 32'h44; data1 = 32'h0;
         #1;
         check_val("lat1_stall", {31'h0, stall1}, (i % 2 == 0) ? 32'h1 : 32'h0);
         check_val("lat1_err", {31'h0, err1}, 32'h0);
      end
      @(negedge clk);
      en1 = 1'b0;
      #1;
      check_val("lat1_idle_rdata", rdata1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
